// File: rtl/cvt_i_fp_mod.sv
// Integer to floating-point converter: three-stage clkEn-gated pipeline producing SNG/DBL/EXT in the 82-bit register layout.
// Optional rounding-mode input port rm[1:0] is enabled by defining CVT_I_FP_RMODE_EN; otherwise nearest-even is fixed.
module cvt_i_fp_mod #(
  parameter logic [15:0] BIAS = 16'h7fff
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clkEn,
  input  logic        en,
  input  logic [64:0] A,
  input  logic        is32b,
  input  logic        isSigned,
  input  logic        isSNG,
  input  logic        isDBL,
  input  logic        isEXT,
`ifdef CVT_I_FP_RMODE_EN
  input  logic [1:0]  rm,
`endif
  output logic [81:0] res,
  output logic        resValid,
  output logic        inexact
);

  typedef enum logic [1:0] {
    FMT_SNG = 2'd0,
    FMT_DBL = 2'd1,
    FMT_EXT = 2'd2
  } fmt_e;

  // Leading-zero count; the highest set bit wins because later iterations overwrite.
  function automatic logic [5:0] lzc64(input logic [63:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) begin
        n = 6'(63 - i);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  logic [63:0] opnd_s;
  logic        sign_s;
  logic [64:0] mag_s;
  fmt_e        fmt_s;

  logic        v1_r;
  logic        sign1_r;
  logic [64:0] mag1_r;
  fmt_e        fmt1_r;

  logic [5:0]  lzc_s;
  logic [63:0] norm_s;
  logic [15:0] exp_s;
  logic        zero_s;

  logic        v2_r;
  logic        sign2_r;
  logic        zero2_r;
  logic [15:0] e2_r;
  logic [63:0] m2_r;
  fmt_e        fmt2_r;

  logic [1:0]  rm_s;
  logic        lsb_s;
  logic        guard_s;
  logic        sticky_s;
  logic        up_s;
  logic [64:0] inc_s;
  logic [64:0] sum_s;
  logic [63:0] mant_s;
  logic [15:0] exp_rnd_s;
  logic [81:0] res_s;
  logic        inexact_s;

  logic [81:0] res_r;
  logic        valid_r;
  logic        inexact_r;

  logic        unused_s;
  assign unused_s = A[64];

  // Stage 1 combinational: operand extension, sign and magnitude.
  always_comb begin
    opnd_s = A[63:0];
    if (is32b) begin
      if (isSigned) begin
        opnd_s = {{32{A[31]}}, A[31:0]};
      end else begin
        opnd_s = {32'd0, A[31:0]};
      end
    end else begin
      opnd_s = A[63:0];
    end
    sign_s = isSigned & opnd_s[63];
    // Negating the sign-extended 65-bit value maps -2^63 to +2^63 without overflow.
    if (sign_s) begin
      mag_s = 65'd0 - {opnd_s[63], opnd_s};
    end else begin
      mag_s = {1'b0, opnd_s};
    end
    if (isEXT) begin
      fmt_s = FMT_EXT;
    end else if (isDBL) begin
      fmt_s = FMT_DBL;
    end else begin
      fmt_s = FMT_SNG;
    end
  end

  // Stage 2 combinational: normalisation and unrounded exponent.
  always_comb begin
    lzc_s  = lzc64(mag1_r[63:0]);
    norm_s = mag1_r[63:0] << lzc_s;
    exp_s  = BIAS + 16'd63 - {10'd0, lzc_s};
    zero_s = ~|mag1_r;
  end

`ifdef CVT_I_FP_RMODE_EN
  logic [1:0] rm1_r;
  logic [1:0] rm2_r;

  // Rounding mode travels alongside the operand through stages 1 and 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rm1_r <= 2'd0;
      rm2_r <= 2'd0;
    end else if (clkEn) begin
      rm1_r <= rm;
      rm2_r <= rm1_r;
    end
  end

  assign rm_s = rm2_r;
`else
  assign rm_s = 2'd0;
`endif

  // Stage 3 combinational: round at the format's precision, renormalise on carry-out.
  always_comb begin
    lsb_s    = 1'b0;
    guard_s  = 1'b0;
    sticky_s = 1'b0;
    inc_s    = 65'd0;
    case (fmt2_r)
      FMT_DBL: begin
        lsb_s    = m2_r[11];
        guard_s  = m2_r[10];
        sticky_s = |m2_r[9:0];
        inc_s    = 65'h800;
      end
      FMT_SNG: begin
        lsb_s    = m2_r[40];
        guard_s  = m2_r[39];
        sticky_s = |m2_r[38:0];
        inc_s    = 65'h100_0000_0000;
      end
      default: begin
        lsb_s    = 1'b0;
        guard_s  = 1'b0;
        sticky_s = 1'b0;
        inc_s    = 65'd0;
      end
    endcase
    case (rm_s)
      2'd0:    up_s = guard_s & (sticky_s | lsb_s);
      2'd1:    up_s = 1'b0;
      2'd2:    up_s = sign2_r & (guard_s | sticky_s);
      2'd3:    up_s = ~sign2_r & (guard_s | sticky_s);
      default: up_s = 1'b0;
    endcase
    sum_s = {1'b0, m2_r} + (up_s ? inc_s : 65'd0);
    if (sum_s[64]) begin
      mant_s    = 64'h8000_0000_0000_0000;
      exp_rnd_s = e2_r + 16'd1;
    end else begin
      mant_s    = sum_s[63:0];
      exp_rnd_s = e2_r;
    end
    inexact_s = ~zero2_r & (guard_s | sticky_s);
  end

  // Stage 3 combinational: pack sign, exponent and mantissa into the register layout.
  always_comb begin
    res_s = 82'd0;
    case (fmt2_r)
      FMT_EXT: begin
        res_s[80]    = sign2_r;
        res_s[79]    = exp_rnd_s[15];
        res_s[81]    = exp_rnd_s[14];
        res_s[78:65] = exp_rnd_s[13:0];
        res_s[64:33] = mant_s[63:32];
        res_s[31:0]  = mant_s[31:0];
      end
      FMT_DBL: begin
        res_s[64]    = sign2_r;
        res_s[79]    = exp_rnd_s[15];
        res_s[81]    = exp_rnd_s[14];
        res_s[62:53] = exp_rnd_s[9:0];
        res_s[52:33] = mant_s[62:43];
        res_s[31:0]  = mant_s[42:11];
      end
      FMT_SNG: begin
        res_s[31]    = sign2_r;
        res_s[30]    = exp_rnd_s[15];
        res_s[32]    = exp_rnd_s[14];
        res_s[29:23] = exp_rnd_s[6:0];
        res_s[22:0]  = mant_s[62:40];
      end
      default: begin
        res_s = 82'd0;
      end
    endcase
    if (zero2_r) begin
      res_s = 82'd0;
    end else begin
      res_s = res_s;
    end
  end

  // Pipeline registers for all three stages; clkEn low freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_r      <= 1'b0;
      sign1_r   <= 1'b0;
      mag1_r    <= 65'd0;
      fmt1_r    <= FMT_SNG;
      v2_r      <= 1'b0;
      sign2_r   <= 1'b0;
      zero2_r   <= 1'b0;
      e2_r      <= 16'd0;
      m2_r      <= 64'd0;
      fmt2_r    <= FMT_SNG;
      res_r     <= 82'd0;
      valid_r   <= 1'b0;
      inexact_r <= 1'b0;
    end else if (clkEn) begin
      v1_r    <= en;
      sign1_r <= sign_s;
      mag1_r  <= mag_s;
      fmt1_r  <= fmt_s;
      v2_r    <= v1_r;
      sign2_r <= sign1_r;
      zero2_r <= zero_s;
      e2_r    <= exp_s;
      m2_r    <= norm_s;
      fmt2_r  <= fmt1_r;
      valid_r <= v2_r;
      // Idle slots leave the last result on res untouched.
      if (v2_r) begin
        res_r     <= res_s;
        inexact_r <= inexact_s;
      end
    end
  end

  assign res      = res_r;
  assign resValid = valid_r;
  assign inexact  = inexact_r;

endmodule

// File: tb/tb_cvt_i_fp_mod.sv
// Directed bench for cvt_i_fp_mod: hand-computed conversions, stall freeze and asynchronous reset.
module tb_cvt_i_fp_mod;

  logic        clk;
  logic        rst;
  logic        clkEn;
  logic        en;
  logic [64:0] A;
  logic        is32b;
  logic        isSigned;
  logic        isSNG;
  logic        isDBL;
  logic        isEXT;
`ifdef CVT_I_FP_RMODE_EN
  logic [1:0]  rm = 2'd0;
`endif
  logic [81:0] res;
  logic        resValid;
  logic        inexact;

  int checks = 0;
  int errors = 0;

  cvt_i_fp_mod dut (
    .clk(clk),
    .rst(rst),
    .clkEn(clkEn),
    .en(en),
    .A(A),
    .is32b(is32b),
    .isSigned(isSigned),
    .isSNG(isSNG),
    .isDBL(isDBL),
    .isEXT(isEXT),
`ifdef CVT_I_FP_RMODE_EN
    .rm(rm),
`endif
    .res(res),
    .resValid(resValid),
    .inexact(inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [81:0] obs, input logic [81:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [81:0] pack_ext(input logic s, input logic [15:0] e, input logic [63:0] m);
    logic [81:0] r;
    r = 82'd0;
    r[80] = s; r[79] = e[15]; r[81] = e[14]; r[78:65] = e[13:0];
    r[64:33] = m[63:32]; r[31:0] = m[31:0];
    return r;
  endfunction

  function automatic logic [81:0] pack_dbl(input logic s, input logic [15:0] e, input logic [51:0] f);
    logic [81:0] r;
    r = 82'd0;
    r[64] = s; r[79] = e[15]; r[81] = e[14]; r[62:53] = e[9:0];
    r[52:33] = f[51:32]; r[31:0] = f[31:0];
    return r;
  endfunction

  function automatic logic [81:0] pack_sng(input logic s, input logic [15:0] e, input logic [22:0] f);
    logic [81:0] r;
    r = 82'd0;
    r[31] = s; r[30] = e[15]; r[32] = e[14]; r[29:23] = e[6:0]; r[22:0] = f;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // fmt: 0 = SNG, 1 = DBL, 2 = EXT
  task automatic set_op(input logic [64:0] a, input logic i32, input logic sg, input logic [1:0] f);
    en = 1'b1; A = a; is32b = i32; isSigned = sg;
    isSNG = (f == 2'd0); isDBL = (f == 2'd1); isEXT = (f == 2'd2);
  endtask

  task automatic run_op(input string tag, input logic [64:0] a, input logic i32, input logic sg,
                        input logic [1:0] f, input logic [81:0] exp_res, input logic exp_inx);
    int n;
    set_op(a, i32, sg, f);
    tick();
    en = 1'b0;
    n = 1;
    while (!resValid && n < 8) begin
      tick();
      n++;
    end
    check_eq({tag, "_lat"}, 82'(n), 82'd3);
    check_eq({tag, "_res"}, res, exp_res);
    check_eq({tag, "_inx"}, 82'(inexact), 82'(exp_inx));
  endtask

  logic [81:0] x_exp, y_exp, z_exp;

  initial begin
    rst = 1'b0; clkEn = 1'b1; en = 1'b0; A = 65'd0;
    is32b = 1'b0; isSigned = 1'b0; isSNG = 1'b0; isDBL = 1'b1; isEXT = 1'b0;
    tick(); tick();
    check_eq("rst_res", res, 82'd0);
    check_eq("rst_valid", 82'(resValid), 82'd0);
    check_eq("rst_inx", 82'(inexact), 82'd0);
    rst = 1'b1;
    tick();

    x_exp = pack_dbl(1'b0, 16'h7fff, 52'd0);
    y_exp = pack_sng(1'b1, 16'h7fff, 23'd0);
    z_exp = pack_dbl(1'b0, 16'h8034, 52'd2);

    run_op("one_dbl",  65'd1, 1'b0, 1'b1, 2'd1, x_exp, 1'b0);
    run_op("neg1_sng", 65'h0_0000_0000_FFFF_FFFF, 1'b1, 1'b1, 2'd0, y_exp, 1'b0);
    run_op("p53_1",    65'h0_0020_0000_0000_0001, 1'b0, 1'b1, 2'd1, pack_dbl(1'b0, 16'h8034, 52'd0), 1'b1);
    run_op("p53_3",    65'h0_0020_0000_0000_0003, 1'b0, 1'b1, 2'd1, z_exp, 1'b1);
    run_op("ones_dbl", 65'h0_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 2'd1, pack_dbl(1'b0, 16'h803f, 52'd0), 1'b1);
    run_op("ones_ext", 65'h0_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 2'd2,
           pack_ext(1'b0, 16'h803e, 64'hFFFF_FFFF_FFFF_FFFF), 1'b0);
    run_op("zero",     65'd0, 1'b0, 1'b1, 2'd1, 82'd0, 1'b0);
    run_op("min64_ext", 65'h0_8000_0000_0000_0000, 1'b0, 1'b1, 2'd2,
           pack_ext(1'b1, 16'h803e, 64'h8000_0000_0000_0000), 1'b0);
    run_op("five_ext", 65'd5, 1'b0, 1'b1, 2'd2, pack_ext(1'b0, 16'h8001, 64'hA000_0000_0000_0000), 1'b0);
    run_op("neg3_dbl", 65'h1_FFFF_FFFF_FFFF_FFFD, 1'b0, 1'b1, 2'd1,
           pack_dbl(1'b1, 16'h8000, 52'h8_0000_0000_0000), 1'b0);
    run_op("sng_tie",  65'h0_0000_0000_0100_0001, 1'b1, 1'b0, 2'd0, pack_sng(1'b0, 16'h8017, 23'd0), 1'b1);
    run_op("sng_up",   65'h0_0000_0000_0100_0003, 1'b1, 1'b0, 2'd0, pack_sng(1'b0, 16'h8017, 23'd2), 1'b1);
    run_op("min32_sng", 65'h1_2345_6789_8000_0000, 1'b1, 1'b1, 2'd0, pack_sng(1'b1, 16'h801e, 23'd0), 1'b0);
    run_op("u32_carry", 65'h1_DEAD_BEEF_FFFF_FFFF, 1'b1, 1'b0, 2'd0, pack_sng(1'b0, 16'h801f, 23'd0), 1'b1);

    // Back-to-back stream with a two-cycle stall; a stray en during the stall must not be captured.
    set_op(65'd1, 1'b0, 1'b1, 2'd1);
    tick();
    set_op(65'h0_0000_0000_FFFF_FFFF, 1'b1, 1'b1, 2'd0);
    tick();
    set_op(65'h0_0020_0000_0000_0003, 1'b0, 1'b1, 2'd1);
    tick();
    check_eq("b2b_x_res", res, x_exp);
    check_eq("b2b_x_vld", 82'(resValid), 82'd1);
    clkEn = 1'b0;
    set_op(65'd5, 1'b0, 1'b0, 2'd2);
    tick();
    check_eq("stall1_res", res, x_exp);
    check_eq("stall1_vld", 82'(resValid), 82'd1);
    tick();
    check_eq("stall2_res", res, x_exp);
    check_eq("stall2_vld", 82'(resValid), 82'd1);
    en = 1'b0;
    clkEn = 1'b1;
    tick();
    check_eq("b2b_y_res", res, y_exp);
    check_eq("b2b_y_vld", 82'(resValid), 82'd1);
    tick();
    check_eq("b2b_z_res", res, z_exp);
    check_eq("b2b_z_inx", 82'(inexact), 82'd1);
    tick();
    check_eq("b2b_end_vld", 82'(resValid), 82'd0);
    check_eq("b2b_hold_res", res, z_exp);
    tick();
    check_eq("b2b_nostray", 82'(resValid), 82'd0);

    // Asynchronous reset between edges with one result showing and another in flight.
    run_op("pre_rst", 65'd1, 1'b0, 1'b1, 2'd1, x_exp, 1'b0);
    set_op(65'h0_0020_0000_0000_0003, 1'b0, 1'b1, 2'd1);
    tick();
    en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_res", res, 82'd0);
    check_eq("arst_vld", 82'(resValid), 82'd0);
    check_eq("arst_inx", 82'(inexact), 82'd0);
    tick();
    #2;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("post_rst_vld", 82'(resValid), 82'd0);
    end
    check_eq("post_rst_res", res, 82'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cvt_i_fp_mod.md
Name: cvt_I_FP_mod

Overview:
- Integer-to-floating-point converter; inverse of the FP-to-integer converter in the FP math pipe.
- Takes a 64-bit or 32-bit signed/unsigned integer and produces a correctly rounded SNG, DBL or EXT value in the 82-bit FP register layout.
- Three-stage pipeline that advances only on clkEn; results go straight to the FP register-file write port.

Parameters:
- BIAS, 16'h7fff, exponent bias of the internal 16-bit exponent (EXT bias; DBL/SNG exponents are the rebased low bits).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- clkEn  input  1  pipeline advance enable; 0 freezes every stage.
- en  input  1  input operand valid, sampled when clkEn=1.
- A  input  65  A[63:0] integer operand; A[64] ignored.
- is32b  input  1  operand is A[31:0]; upper bits ignored.
- isSigned  input  1  two's-complement operand; else unsigned.
- isSNG, isDBL, isEXT  input  1 each  target format, one-hot, sampled with en.
- res  output  82  converted value in register layout.
- resValid  output  1  res valid this cycle.
- inexact  output  1  rounding discarded nonzero bits; qualified by resValid.

Behaviour:
- Reset: all stage registers, res, resValid and inexact are 0 while rst=0, regardless of clk. Reset mid-operation drops all in-flight results.
- Latency: exactly 3 clkEn=1 edges from input capture to res/resValid. clkEn=0 holds all stages and outputs unchanged. Throughput is one operation per enabled cycle. A stage with en=0 propagates valid=0; res is then don't-care but held stable.
- Stage 1: sign-extend or zero-extend the 32-bit operand. sign = isSigned & MSB. Take the magnitude with a 64-bit negation. The 65-bit magnitude handles -2^63 as 2^63.
- Stage 2: 6-bit leading-zero count of the magnitude. Left-normalise so mantissa bit 63 = 1. Unrounded exponent E = BIAS + 63 - lzc (16-bit). Zero magnitude sets a zero flag.
- Stage 3, rounding position:
  - EXT: keep 64 bits; always exact.
  - DBL: keep 53 bits.
  - SNG: keep 24 bits.
- Stage 3, rounding rule: round-to-nearest-even unless the optional feature is enabled. A mantissa carry-out renormalises to 1.0 and increments E. inexact = OR of discarded bits.
- Overflow is impossible (max E = BIAS+64).
- Output layout, all unlisted bits 0:
  - EXT: res[80]=sign; res[79]=E[15]; res[81]=E[14]; res[78:65]=E[13:0]; res[64:33]=m[63:32]; res[31:0]=m[31:0] (explicit integer bit kept).
  - DBL: res[64]=sign; res[79]=E[15]; res[81]=E[14]; res[62:53]=E[9:0]; fraction res[52:33], res[31:0].
  - SNG: res[31]=sign; res[30]=E[15]; res[32]=E[14]; res[29:23]=E[6:0]; fraction res[22:0].
- Zero input: res=0 (positive zero), inexact=0 for all formats.
- More than one or none of isSNG/isDBL/isEXT set with en=1: undefined res; resValid still asserts. Verification must not drive this.

Optional Feature:
- Macro CVT_I_FP_RMODE_EN.
- Defined: extra input port rm[1:0] is sampled with en and carried down the pipe. Encodings: 0 = nearest-even, 1 = toward zero, 2 = toward -inf, 3 = toward +inf. Directed modes use sign and the sticky bit.
- Undefined: no rm port; nearest-even is hard-wired.

Test Plan:
- Signed 64b A=1, isDBL -> after 3 clkEn edges, resValid=1, res[79]=0, res[81]=1, res[62:53]=0x3ff, fraction 0, inexact=0.
- Signed 32b A=0xFFFFFFFF, isSNG -> res[31]=1, res[30]=0, res[32]=1, res[29:23]=0x7f, res[22:0]=0 (-1.0).
- A=2^53+1, isDBL -> rounds to 2^53, E=0x7fff+53, inexact=1. A=2^53+3 -> 2^53+4, inexact=1.
- Unsigned 64b A=0xFFFFFFFFFFFFFFFF, isDBL -> carry-out case: E=0x803f, fraction 0, inexact=1. Same value with isEXT -> E=0x803e, mantissa all ones, inexact=0.
- Back-to-back ops with clkEn low for 2 cycles mid-stream -> outputs frozen during the stall; result order and values preserved.
- Ops in flight, then rst=0 asynchronously between edges -> resValid=0 and res=0 immediately; no stale result after rst returns to 1. A=0 -> res=0, inexact=0.
